// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button edge detect, IDLE/RUN/LAP/PAUSE sequencing,
// tick divider and MM:SS BCD counter with registered display/status outputs.
module stopwatch_ctrl #(
   parameter int CLK_FREQ_HZ = 100_000_000,
   parameter int TICK_HZ     = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        btn_start,
   input  logic        btn_clear,
   input  logic        btn_lap,
   output logic [15:0] disp_bcd,
   output logic        running,
   output logic        lap_active,
   output logic        tick,
   output logic        rollover
);

   localparam int DIV = CLK_FREQ_HZ / TICK_HZ;
   localparam int DW  = $clog2(DIV);
   localparam logic [DW-1:0] DIV_MAX = DW'(DIV - 1);

   typedef enum logic [1:0] {IDLE, RUN, LAP, PAUSE} state_t;

   state_t        state;
   logic [15:0]   count;
   logic [15:0]   latch;
   logic [DW-1:0] div;
   logic [2:0]    prev;   // {lap, clear, start}

   logic          ev_start, ev_clear, ev_lap;
   logic          adv, do_tick, roll;
   logic [15:0]   cnt_adv;
   logic [DW-1:0] div_adv;

   // Ripple increment of {min_t,min_o,sec_t,sec_o}; wraps 59:59 -> 00:00.
   function automatic logic [15:0] bcd_inc(input logic [15:0] v);
      logic [15:0] r;
      r = v;
      if (v[3:0] != 4'd9) r[3:0] = v[3:0] + 4'd1;
      else begin
         r[3:0] = 4'd0;
         if (v[7:4] != 4'd5) r[7:4] = v[7:4] + 4'd1;
         else begin
            r[7:4] = 4'd0;
            if (v[11:8] != 4'd9) r[11:8] = v[11:8] + 4'd1;
            else begin
               r[11:8] = 4'd0;
               if (v[15:12] != 4'd5) r[15:12] = v[15:12] + 4'd1;
               else r[15:12] = 4'd0;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      ev_start = btn_start & ~prev[0];
      ev_clear = btn_clear & ~prev[1];
      ev_lap   = btn_lap   & ~prev[2];
      // Timebase advances on the current state; a clear suppresses this edge's tick.
      adv      = ((state == RUN) || (state == LAP)) && !ev_clear;
      do_tick  = adv && (div == DIV_MAX);
      roll     = do_tick && (count == 16'h5959);
      cnt_adv  = do_tick ? bcd_inc(count) : count;
      div_adv  = adv ? ((div == DIV_MAX) ? '0 : div + 1'b1) : div;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         count      <= '0;
         latch      <= '0;
         div        <= '0;
         prev       <= 3'b111;
         disp_bcd   <= '0;
         running    <= 1'b0;
         lap_active <= 1'b0;
         tick       <= 1'b0;
         rollover   <= 1'b0;
      end else begin
         prev     <= {btn_lap, btn_clear, btn_start};
         tick     <= do_tick;
         rollover <= roll;
         count    <= cnt_adv;
         div      <= div_adv;
         disp_bcd <= cnt_adv;
         if (ev_clear) begin
            state      <= IDLE;
            count      <= '0;
            latch      <= '0;
            div        <= '0;
            disp_bcd   <= '0;
            running    <= 1'b0;
            lap_active <= 1'b0;
         end else begin
            case (state)
               IDLE:
                  if (ev_start) begin
                     state   <= RUN;
                     div     <= '0;
                     running <= 1'b1;
                  end
               RUN:
                  if (ev_start) begin
                     state   <= PAUSE;
                     running <= 1'b0;
                  end else if (ev_lap) begin
                     state      <= LAP;
                     latch      <= cnt_adv;
                     lap_active <= 1'b1;
                  end
               LAP:
                  if (ev_start) begin
                     state      <= PAUSE;
                     running    <= 1'b0;
                     lap_active <= 1'b0;
                  end else if (ev_lap) begin
                     state      <= RUN;
                     lap_active <= 1'b0;
                  end else begin
                     disp_bcd <= latch;
                  end
               PAUSE:
                  if (ev_start) begin
                     state   <= RUN;
                     running <= 1'b1;
                  end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench for stopwatch_ctrl: a seconds-based reference model queues
// the expected outputs per edge, a monitor pops and compares after each edge.
module tb_stopwatch_ctrl;

   localparam int DIV = 10;
   localparam int M_IDLE = 0, M_RUN = 1, M_LAP = 2, M_PAUSE = 3;

   logic        clk = 1'b0;
   logic        rst = 1'b0, btn_start = 1'b0, btn_clear = 1'b0, btn_lap = 1'b0;
   logic [15:0] disp_bcd;
   logic        running, lap_active, tick, rollover;

   stopwatch_ctrl #(.CLK_FREQ_HZ(10), .TICK_HZ(1)) dut (
      .clk(clk), .rst(rst), .btn_start(btn_start), .btn_clear(btn_clear),
      .btn_lap(btn_lap), .disp_bcd(disp_bcd), .running(running),
      .lap_active(lap_active), .tick(tick), .rollover(rollover)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] disp;
      logic        run;
      logic        lap;
      logic        tck;
      logic        roll;
   } exp_t;

   exp_t sb[$];
   exp_t m_e, m_a;
   int   n_tests = 0, n_fail = 0, n_ticks = 0, n_rolls = 0, cyc = 0;

   // Reference model: elapsed seconds, cycles since last tick, and a mode.
   int     m_mode = M_IDLE, m_secs = 0, m_phase = 0, m_latch = 0;
   bit [2:0] m_prev = 3'b111;

   function automatic logic [15:0] to_bcd(input int s);
      int mm, ss;
      mm = s / 60;
      ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   task automatic step(input bit s, input bit c, input bit l, input bit r);
      exp_t e;
      bit   es, ec, el, act;
      @(negedge clk);
      btn_start = s; btn_clear = c; btn_lap = l; rst = r;
      e = '0;
      if (r) begin
         m_mode = M_IDLE; m_secs = 0; m_phase = 0; m_latch = 0; m_prev = 3'b111;
      end else begin
         es = s & !m_prev[0];
         ec = c & !m_prev[1];
         el = l & !m_prev[2];
         m_prev = {l, c, s};
         act = (m_mode == M_RUN) || (m_mode == M_LAP);
         if (ec) begin
            m_mode = M_IDLE; m_secs = 0; m_phase = 0;
         end else begin
            if (act) begin
               m_phase++;
               if (m_phase == DIV) begin
                  m_phase = 0;
                  m_secs  = (m_secs + 1) % 3600;
                  e.tck   = 1'b1;
                  e.roll  = (m_secs == 0);
               end
            end
            if (es) begin
               if (m_mode == M_IDLE) begin m_mode = M_RUN; m_phase = 0; end
               else if (m_mode == M_PAUSE) m_mode = M_RUN;
               else m_mode = M_PAUSE;
            end else if (el) begin
               if (m_mode == M_RUN) begin m_mode = M_LAP; m_latch = m_secs; end
               else if (m_mode == M_LAP) m_mode = M_RUN;
            end
         end
      end
      e.run  = (m_mode == M_RUN) || (m_mode == M_LAP);
      e.lap  = (m_mode == M_LAP);
      e.disp = to_bcd(m_mode == M_LAP ? m_latch : m_secs);
      sb.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic settle();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Monitor: one expected record per clock edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (sb.size() > 0) begin
         m_e = sb.pop_front();
         m_a = {disp_bcd, running, lap_active, tick, rollover};
         n_tests++;
         if (m_a !== m_e) begin
            n_fail++;
            $display("FAIL sb cyc %0d: got disp=%h run=%b lap=%b tick=%b roll=%b, expected disp=%h run=%b lap=%b tick=%b roll=%b",
                     cyc, m_a.disp, m_a.run, m_a.lap, m_a.tck, m_a.roll,
                     m_e.disp, m_e.run, m_e.lap, m_e.tck, m_e.roll);
         end
         if (tick) n_ticks++;
         if (rollover) n_rolls++;
      end
   end

   initial begin
      bit s, c, l, r;
      // Reset with start held, then released: no press, no ticks.
      step(1, 0, 0, 1); step(1, 0, 0, 1);
      repeat (3) step(1, 0, 0, 0);
      n_ticks = 0;
      idle(100);
      settle();
      chk("t1_ticks", 16'(n_ticks), 16'd0);
      chk("t1_disp", disp_bcd, 16'h0000);
      chk("t1_running", 16'(running), 16'd0);

      // Start and run 125 cycles.
      n_ticks = 0;
      step(1, 0, 0, 0);
      idle(125);
      settle();
      chk("t2_ticks", 16'(n_ticks), 16'd12);
      chk("t2_disp", disp_bcd, 16'h0012);
      chk("t2_running", 16'(running), 16'd1);

      // All three buttons at once at 00:07: clear wins.
      step(0, 1, 0, 0);
      step(1, 0, 0, 0);
      idle(75);
      settle();
      chk("t3_pre", disp_bcd, 16'h0007);
      step(1, 1, 1, 0);
      settle();
      chk("t3_disp", disp_bcd, 16'h0000);
      chk("t3_running", 16'(running), 16'd0);
      idle(2);

      // Run to 59:58, lap, ride through the rollover, release lap.
      n_rolls = 0;
      step(1, 0, 0, 0);
      idle(35980);
      step(0, 0, 1, 0);
      settle();
      chk("t4_lap_disp", disp_bcd, 16'h5958);
      chk("t4_lap_active", 16'(lap_active), 16'd1);
      idle(15);
      settle();
      chk("t4_frozen_mid", disp_bcd, 16'h5958);
      idle(15);
      settle();
      chk("t4_frozen_end", disp_bcd, 16'h5958);
      chk("t4_rollovers", 16'(n_rolls), 16'd1);
      step(0, 0, 1, 0);
      settle();
      chk("t4_release", disp_bcd, 16'h0001);

      // Pause with divider at 6, hold, resume: tick 4 cycles later.
      idle(3);
      step(1, 0, 0, 0);
      settle();
      chk("t5_paused", 16'(running), 16'd0);
      n_ticks = 0;
      idle(50);
      settle();
      chk("t5_no_ticks", 16'(n_ticks), 16'd0);
      chk("t5_held", disp_bcd, 16'h0001);
      step(1, 0, 0, 0);
      idle(3);
      settle();
      chk("t5_tick_early", 16'(tick), 16'd0);
      idle(1);
      settle();
      chk("t5_tick", 16'(tick), 16'd1);
      chk("t5_disp", disp_bcd, 16'h0002);

      // Held lap: one entry only. Lap in PAUSE/IDLE ignored.
      repeat (40) step(0, 0, 1, 0);
      settle();
      chk("t6_lap_held", 16'(lap_active), 16'd1);
      idle(1);
      step(0, 0, 1, 0);
      settle();
      chk("t6_lap_exit", 16'({running, lap_active}), 16'b10);
      step(1, 0, 0, 0);
      step(0, 0, 1, 0);
      settle();
      chk("t6_lap_pause", 16'({running, lap_active}), 16'b00);
      step(0, 1, 0, 0);
      step(0, 0, 1, 0);
      settle();
      chk("t6_lap_idle", 16'({running, lap_active}), 16'b00);
      chk("t6_idle_disp", disp_bcd, 16'h0000);

      // Clear on the tick edge, then reset on the tick edge.
      idle(1);
      step(1, 0, 0, 0);
      idle(9);
      step(0, 1, 0, 0);
      settle();
      chk("clr_tick", 16'({tick, rollover}), 16'd0);
      chk("clr_disp", disp_bcd, 16'h0000);
      step(1, 0, 0, 0);
      idle(9);
      step(0, 0, 0, 1);
      settle();
      chk("rst_tick", 16'({tick, running}), 16'd0);

      // Randomized button activity.
      s = 0; c = 0; l = 0;
      repeat (4000) begin
         s = s ^ ($urandom_range(0, 19) == 0);
         c = c ^ ($urandom_range(0, 149) == 0);
         l = l ^ ($urandom_range(0, 24) == 0);
         r = ($urandom_range(0, 499) == 0);
         step(s, c, l, r);
      end
      idle(2);
      settle();
      chk("sb_drain", 16'(sb.size()), 16'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
